// File: rtl/wir_pkg.sv
// -----------------------------------------------------------------------------
// wir_pkg
//   Shared definitions for the IEEE 1500 wrapper instruction register.
//   - wir_op_e    : instruction opcodes. They are zero-extended to the
//                   configured instruction width by the users of this package.
//   - WIR_CAPTURE : fixed pattern loaded into the WIR shift stage on capture.
//   - is_wbr_op() : true for instructions that route the boundary register.
// -----------------------------------------------------------------------------
package wir_pkg;

  typedef enum logic [1:0] {
    WS_BYPASS = 2'd0,
    WS_EXTEST = 2'd1,
    WS_INTEST = 2'd2
  } wir_op_e;

  localparam logic [1:0] WIR_CAPTURE = 2'b01;

  function automatic logic is_wbr_op(input wir_op_e op);
    return (op == WS_EXTEST) || (op == WS_INTEST);
  endfunction

endpackage

// File: rtl/wso_retime.sv
// -----------------------------------------------------------------------------
// wso_retime
//   Falling-edge output flop for a 1500 serial stage. Retiming the serial
//   output by half a cycle gives the downstream stage a full half period of
//   hold margin on its rising-edge capture.
// Ports
//   i_clk : serial clock (output updates on its falling edge)
//   i_rst : asynchronous active-high reset, output returns to 0
//   i_d   : serial data to retime
//   o_q   : retimed serial data
// -----------------------------------------------------------------------------
module wso_retime (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) o_q <= 1'b0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/wir_ctrl.sv
// -----------------------------------------------------------------------------
// wir_ctrl
//   IEEE 1500 Wrapper Instruction Register with instruction decode and the
//   wrapper serial output mux. Generates the bypass/boundary register
//   controls from the active instruction and retimes WSO on falling wrck.
//
// Parameters
//   WIR_WIDTH   : instruction bits (min 2)
// Configuration macro
//   WIR_PARITY_EN : adds an odd-parity bit at the LSB of the WIR shift stage;
//                   a parity failure on update forces WS_BYPASS and sets the
//                   sticky wir_err flag. Undefined: wir_err is tied 0.
// Ports
//   wrck, wrst                       : clock, async active-high reset
//   selectwir                        : 1 = WIR path, 0 = data register path
//   capturewr, shiftwr, updatewr     : wrapper scan controls
//   wsi                              : wrapper serial input
//   wby_wso, wbr_wso                 : serial outputs of WBY / WBR
//   shiftwby                         : WBY shift enable
//   shiftwbr, capturewbr, updatewbr  : WBR controls
//   extest_mode, intest_mode         : active-instruction flags
//   wso                              : wrapper serial output (negedge retimed)
//   wir_err                          : sticky parity error
// -----------------------------------------------------------------------------
module wir_ctrl
  import wir_pkg::*;
#(
  parameter int WIR_WIDTH = 3
) (
  input  logic wrck,
  input  logic wrst,
  input  logic selectwir,
  input  logic capturewr,
  input  logic shiftwr,
  input  logic updatewr,
  input  logic wsi,
  input  logic wby_wso,
  input  logic wbr_wso,
  output logic shiftwby,
  output logic shiftwbr,
  output logic capturewbr,
  output logic updatewbr,
  output logic extest_mode,
  output logic intest_mode,
  output logic wso,
  output logic wir_err
);

`ifdef WIR_PARITY_EN
  localparam int SR_W = WIR_WIDTH + 1;
  localparam logic [SR_W-1:0] SR_CAPTURE = {WIR_WIDTH'(WIR_CAPTURE), 1'b0};
`else
  localparam int SR_W = WIR_WIDTH;
  localparam logic [SR_W-1:0] SR_CAPTURE = SR_W'(WIR_CAPTURE);
`endif

  localparam logic [WIR_WIDTH-1:0] OP_BYPASS = WIR_WIDTH'(WS_BYPASS);
  localparam logic [WIR_WIDTH-1:0] OP_EXTEST = WIR_WIDTH'(WS_EXTEST);
  localparam logic [WIR_WIDTH-1:0] OP_INTEST = WIR_WIDTH'(WS_INTEST);

  logic [SR_W-1:0]      r_sr;
  logic [WIR_WIDTH-1:0] r_ir;
  logic [WIR_WIDTH-1:0] w_opcode;
  wir_op_e              w_op;
  logic                 w_wbr;
  logic                 w_wso_d;

  // Opcode field of the shift stage; the parity bit (if any) sits below it.
  assign w_opcode = r_sr[SR_W-1 -: WIR_WIDTH];

`ifdef WIR_PARITY_EN
  logic r_err;
  assign wir_err = r_err;
`else
  assign wir_err = 1'b0;
`endif

  // Shift stage and instruction register. Update samples r_sr as it was
  // before this edge, so a same-edge capture/shift never leaks into wir_ir.
  always_ff @(posedge wrck or posedge wrst) begin
    if (wrst) begin
      r_sr  <= '0;
      r_ir  <= OP_BYPASS;
`ifdef WIR_PARITY_EN
      r_err <= 1'b0;
`endif
    end else if (selectwir) begin
      if (capturewr)    r_sr <= SR_CAPTURE;
      else if (shiftwr) r_sr <= {wsi, r_sr[SR_W-1:1]};

      if (updatewr) begin
`ifdef WIR_PARITY_EN
        // Odd parity across opcode plus parity bit.
        if (^r_sr) begin
          r_ir <= w_opcode;
        end else begin
          r_ir  <= OP_BYPASS;
          r_err <= 1'b1;
        end
`else
        r_ir <= w_opcode;
`endif
      end
    end
  end

  // Reserved encodings fall back to bypass.
  always_comb begin
    w_op = WS_BYPASS;
    if (r_ir == OP_EXTEST)      w_op = WS_EXTEST;
    else if (r_ir == OP_INTEST) w_op = WS_INTEST;
  end

  assign w_wbr       = is_wbr_op(w_op);
  assign extest_mode = (w_op == WS_EXTEST);
  assign intest_mode = (w_op == WS_INTEST);

  assign shiftwby   = ~selectwir & shiftwr   & ~w_wbr;
  assign shiftwbr   = ~selectwir & shiftwr   &  w_wbr;
  assign capturewbr = ~selectwir & capturewr &  w_wbr;
  assign updatewbr  = ~selectwir & updatewr  &  w_wbr;

  assign w_wso_d = selectwir ? r_sr[0] : (w_wbr ? wbr_wso : wby_wso);

  wso_retime u_wso_retime (
    .i_clk (wrck),
    .i_rst (wrst),
    .i_d   (w_wso_d),
    .o_q   (wso)
  );

endmodule

// File: tb/tb_wir_ctrl.sv
module tb_wir_ctrl;

  localparam int W = 3;
`ifdef WIR_PARITY_EN
  localparam int SRW  = W + 1;
  localparam int PB   = 1;
  localparam int CAPV = 2;
`else
  localparam int SRW  = W;
  localparam int PB   = 0;
  localparam int CAPV = 1;
`endif

  logic wrck = 1'b0;
  logic wrst = 1'b0;
  logic selectwir = 1'b0, capturewr = 1'b0, shiftwr = 1'b0, updatewr = 1'b0;
  logic wsi = 1'b0, wby_wso = 1'b0, wbr_wso = 1'b0;
  logic shiftwby, shiftwbr, capturewbr, updatewbr;
  logic extest_mode, intest_mode, wso, wir_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: shift register and instruction as plain integers.
  int m_sr  = 0;
  int m_ir  = 0;
  bit m_wso = 1'b0;
  bit m_err = 1'b0;

  wir_ctrl #(.WIR_WIDTH(W)) dut (
    .wrck        (wrck),
    .wrst        (wrst),
    .selectwir   (selectwir),
    .capturewr   (capturewr),
    .shiftwr     (shiftwr),
    .updatewr    (updatewr),
    .wsi         (wsi),
    .wby_wso     (wby_wso),
    .wbr_wso     (wbr_wso),
    .shiftwby    (shiftwby),
    .shiftwbr    (shiftwbr),
    .capturewbr  (capturewbr),
    .updatewbr   (updatewbr),
    .extest_mode (extest_mode),
    .intest_mode (intest_mode),
    .wso         (wso),
    .wir_err     (wir_err)
  );

  always #5 wrck = ~wrck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 1 = EXTEST, 2 = INTEST, 0 = bypass (including reserved codes)
  function automatic int mode_of(input int ir);
    if (ir == 1) return 1;
    if (ir == 2) return 2;
    return 0;
  endfunction

  task automatic check_comb();
    int md;
    md = mode_of(m_ir);
    chk("shiftwby",    shiftwby,    !selectwir && shiftwr   && md == 0);
    chk("shiftwbr",    shiftwbr,    !selectwir && shiftwr   && md != 0);
    chk("capturewbr",  capturewbr,  !selectwir && capturewr && md != 0);
    chk("updatewbr",   updatewbr,   !selectwir && updatewr  && md != 0);
    chk("extest_mode", extest_mode, md == 1);
    chk("intest_mode", intest_mode, md == 2);
  endtask

  // One wrck cycle: inputs applied just after a falling edge, combinational
  // outputs checked before the rising edge, wso checked after the next fall.
  task automatic cyc(input logic sel, input logic cap, input logic sh, input logic upd,
                     input logic si, input logic wby, input logic wbr);
    int prev, op;
    selectwir = sel; capturewr = cap; shiftwr = sh; updatewr = upd;
    wsi = si; wby_wso = wby; wbr_wso = wbr;
    #1;
    check_comb();
    @(posedge wrck);
    prev = m_sr;
    if (sel) begin
      if (cap)     m_sr = CAPV;
      else if (sh) m_sr = (m_sr >> 1) | (int'(si) << (SRW - 1));
      if (upd) begin
        op = (prev >> PB) & ((1 << W) - 1);
        if (PB == 0 || ($countones(prev) % 2) == 1) m_ir = op;
        else begin
          m_ir  = 0;
          m_err = 1'b1;
        end
      end
    end
    @(negedge wrck);
    if (sel)                   m_wso = m_sr[0];
    else if (mode_of(m_ir) != 0) m_wso = wbr;
    else                       m_wso = wby;
    #1;
    chk("wso", wso, m_wso);
    chk("wir_err", wir_err, m_err);
  endtask

  // Asynchronous reset pulse between clock edges, DR shift held active.
  task automatic do_reset();
    selectwir = 1'b0; capturewr = 1'b0; shiftwr = 1'b1; updatewr = 1'b0;
    wrst = 1'b1;
    m_sr = 0; m_ir = 0; m_wso = 1'b0; m_err = 1'b0;
    #1;
    chk("rst_wso", wso, 1'b0);
    chk("rst_shiftwby", shiftwby, 1'b1);
    chk("rst_extest", extest_mode, 1'b0);
    chk("rst_err", wir_err, 1'b0);
    #1;
    wrst = 1'b0;
  endtask

  task automatic shift_in(input logic [SRW-1:0] bits);
    for (int i = 0; i < SRW; i++) cyc(1, 0, 1, 0, bits[i], 0, 0);
  endtask

  // Shift an opcode LSB-first (parity bit first when present), then update.
  task automatic load_op(input logic [W-1:0] op, input logic good);
    logic [SRW-1:0] bits;
`ifdef WIR_PARITY_EN
    bits = {op, (~^op) ^ ~good};
`else
    bits = op;
`endif
    shift_in(bits);
    cyc(1, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    logic [SRW-1:0] ext_bits;
`ifdef WIR_PARITY_EN
    ext_bits = {3'b001, 1'b0};
`else
    ext_bits = 3'b001;
`endif
    @(negedge wrck); #1;

    // 1: reset in the middle of a WIR shift
    cyc(1, 0, 1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 1, 0, 0);
    do_reset();

    // 2: load EXTEST, then DR shift routes to the boundary register
    load_op(3'b001, 1'b1);
    chk("t2_extest", extest_mode, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 1);
    chk("t2_shiftwbr", shiftwbr, 1'b1);
    chk("t2_shiftwby", shiftwby, 1'b0);

    // 3: capture then shift out three bits
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, 0);

    // 4: reserved opcode behaves as bypass
    load_op(3'b111, 1'b1);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("t4_shiftwby", shiftwby, 1'b1);
    chk("t4_wso", wso, 1'b1);

    // 5: capture wins over shift; update sees the pre-shift value
    cyc(1, 1, 1, 0, 1, 0, 0);
    do_reset();
    shift_in(ext_bits);
    cyc(1, 0, 1, 1, 1, 0, 0);
    chk("t5_extest", extest_mode, 1'b1);

`ifdef WIR_PARITY_EN
    // 6: bad parity forces bypass and sets the sticky error
    load_op(3'b001, 1'b0);
    chk("t6_bad_extest", extest_mode, 1'b0);
    chk("t6_bad_err", wir_err, 1'b1);
    load_op(3'b001, 1'b1);
    chk("t6_good_extest", extest_mode, 1'b1);
    chk("t6_sticky_err", wir_err, 1'b1);
    do_reset();
`endif

    load_op(3'b010, 1'b1);
    chk("intest_load", intest_mode, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
